// File: rtl/uart_tx_arbiter.sv
// rtl/uart_tx_arbiter.sv - round-robin byte arbiter feeding an 8N1 UART transmitter (optional macro: UART_ARB_LOCK_EN)
module uart_tx_arbiter #(
  parameter int NREQ    = 4,
  parameter int CLK_MHZ = 50,
  parameter int BAUD    = 115200
) (
  input  logic                    clk,
  input  logic                    rstn,
  input  logic [NREQ-1:0]         req_valid,
  input  logic [8*NREQ-1:0]       req_data,
  output logic [NREQ-1:0]         req_ready,
`ifdef UART_ARB_LOCK_EN
  input  logic [NREQ-1:0]         req_lock,
`endif
  output logic                    uart_tx,
  output logic                    busy,
  output logic [$clog2(NREQ)-1:0] grant_id
);

  localparam int DIV   = (CLK_MHZ * 1000000) / BAUD;
  localparam int DIV_W = (DIV > 1) ? $clog2(DIV) : 1;
  localparam int ID_W  = $clog2(NREQ);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_START = 2'd1,
    S_DATA  = 2'd2,
    S_STOP  = 2'd3
  } state_t;

  state_t            state_q, state_d;
  logic [7:0]        shift_q, shift_d;
  logic [2:0]        bit_cnt_q, bit_cnt_d;
  logic [DIV_W-1:0]  div_cnt_q, div_cnt_d;
  logic [ID_W-1:0]   ptr_q, ptr_d;
  logic [ID_W-1:0]   grant_id_q, grant_id_d;
  logic              uart_tx_q, uart_tx_d;
`ifdef UART_ARB_LOCK_EN
  logic              granted_q, granted_d;
`endif

  logic [NREQ-1:0]   eligible;
  logic              found_hi, found_lo, win_found;
  logic [ID_W-1:0]   idx_hi, idx_lo, win_idx;
  logic [NREQ-1:0]   win_onehot;
  logic [7:0]        win_byte;
  logic              div_last;

  // Round-robin winner search: first eligible index above ptr, else first at or below it
  always_comb begin
    eligible = req_valid;
`ifdef UART_ARB_LOCK_EN
    // A locked last-winner is the only candidate; nobody else may cut in
    if (granted_q && req_lock[ptr_q]) begin
      eligible = req_valid & (NREQ'(1) << ptr_q);
    end
`endif
    found_hi = 1'b0;
    found_lo = 1'b0;
    idx_hi   = '0;
    idx_lo   = '0;
    // Scanning downward lets the lowest matching index overwrite the others
    for (int j = NREQ - 1; j >= 0; j--) begin
      if (eligible[j] && (ID_W'(j) > ptr_q)) begin
        found_hi = 1'b1;
        idx_hi   = ID_W'(j);
      end
      if (eligible[j] && (ID_W'(j) <= ptr_q)) begin
        found_lo = 1'b1;
        idx_lo   = ID_W'(j);
      end
    end
    win_found  = found_hi | found_lo;
    win_idx    = found_hi ? idx_hi : idx_lo;
    win_onehot = NREQ'(1) << win_idx;
    win_byte   = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (ID_W'(i) == win_idx) begin
        win_byte = req_data[8*i +: 8];
      end
    end
  end

  // Accept strobe is only offered while idle and out of reset
  always_comb begin
    req_ready = '0;
    if (rstn && (state_q == S_IDLE) && win_found) begin
      req_ready = win_onehot;
    end
  end

  // Frame sequencer: next state, shift register, counters and the registered line level
  always_comb begin
    state_d    = state_q;
    shift_d    = shift_q;
    bit_cnt_d  = bit_cnt_q;
    div_cnt_d  = div_cnt_q;
    ptr_d      = ptr_q;
    grant_id_d = grant_id_q;
    uart_tx_d  = uart_tx_q;
`ifdef UART_ARB_LOCK_EN
    granted_d  = granted_q;
`endif
    div_last   = (div_cnt_q == DIV_W'(DIV - 1));

    unique case (state_q)
      S_IDLE: begin
        uart_tx_d = 1'b1;
        if (win_found) begin
          shift_d    = win_byte;
          ptr_d      = win_idx;
          grant_id_d = win_idx;
          bit_cnt_d  = '0;
          div_cnt_d  = '0;
          uart_tx_d  = 1'b0;
          state_d    = S_START;
`ifdef UART_ARB_LOCK_EN
          granted_d  = 1'b1;
`endif
        end
      end
      S_START: begin
        if (div_last) begin
          div_cnt_d = '0;
          uart_tx_d = shift_q[0];
          state_d   = S_DATA;
        end else begin
          div_cnt_d = div_cnt_q + 1'b1;
        end
      end
      S_DATA: begin
        if (div_last) begin
          div_cnt_d = '0;
          shift_d   = shift_q >> 1;
          bit_cnt_d = bit_cnt_q + 1'b1;
          if (bit_cnt_q == 3'd7) begin
            uart_tx_d = 1'b1;
            state_d   = S_STOP;
          end else begin
            uart_tx_d = shift_q[1];
          end
        end else begin
          div_cnt_d = div_cnt_q + 1'b1;
        end
      end
      S_STOP: begin
        uart_tx_d = 1'b1;
        if (div_last) begin
          div_cnt_d = '0;
          state_d   = S_IDLE;
        end else begin
          div_cnt_d = div_cnt_q + 1'b1;
        end
      end
      default: begin
        state_d   = S_IDLE;
        uart_tx_d = 1'b1;
      end
    endcase
  end

  // State register; reset aborts any frame and parks ptr so requester 0 wins first
  always_ff @(posedge clk) begin
    if (!rstn) begin
      state_q    <= S_IDLE;
      shift_q    <= '0;
      bit_cnt_q  <= '0;
      div_cnt_q  <= '0;
      ptr_q      <= ID_W'(NREQ - 1);
      grant_id_q <= '0;
      uart_tx_q  <= 1'b1;
`ifdef UART_ARB_LOCK_EN
      granted_q  <= 1'b0;
`endif
    end else begin
      state_q    <= state_d;
      shift_q    <= shift_d;
      bit_cnt_q  <= bit_cnt_d;
      div_cnt_q  <= div_cnt_d;
      ptr_q      <= ptr_d;
      grant_id_q <= grant_id_d;
      uart_tx_q  <= uart_tx_d;
`ifdef UART_ARB_LOCK_EN
      granted_q  <= granted_d;
`endif
    end
  end

  assign uart_tx  = uart_tx_q;
  assign busy     = (state_q != S_IDLE);
  assign grant_id = grant_id_q;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// tb/tb_uart_tx_arbiter.sv - self-checking bench for uart_tx_arbiter with a frame-level reference model
module tb_uart_tx_arbiter;

  localparam int NREQ  = 4;
  localparam int DIV   = 4;
  localparam int FRAME = 10 * DIV;

  logic              clk = 1'b0;
  logic              rstn = 1'b0;
  logic [NREQ-1:0]   req_valid = '0;
  logic [8*NREQ-1:0] req_data = '0;
`ifdef UART_ARB_LOCK_EN
  logic [NREQ-1:0]   req_lock = '0;
`endif
  logic [NREQ-1:0]   req_ready;
  logic              uart_tx;
  logic              busy;
  logic [1:0]        grant_id;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  uart_tx_arbiter #(
    .NREQ(NREQ),
    .CLK_MHZ(1),
    .BAUD(250000)
  ) dut (
    .clk(clk),
    .rstn(rstn),
    .req_valid(req_valid),
    .req_data(req_data),
    .req_ready(req_ready),
`ifdef UART_ARB_LOCK_EN
    .req_lock(req_lock),
`endif
    .uart_tx(uart_tx),
    .busy(busy),
    .grant_id(grant_id)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference model: a frame is "accept cycle + byte"; outputs follow from the elapsed offset
  int              cyc = 0;
  int              m_ptr = NREQ - 1;
  int              m_gid = 0;
  int              m_t = 0;
  bit              m_busy = 1'b0;
  bit              m_granted = 1'b0;
  logic [7:0]      m_byte = '0;
  int              m_off;
  int              m_idx;
  int              m_win;
  bit              m_found;
  logic [NREQ-1:0] m_elig;
  logic [NREQ-1:0] exp_rdy;
  logic            exp_tx;
  int              m_log[$];

  always @(negedge clk) begin
    cyc++;
    m_off = cyc - m_t;
    if (m_busy && m_off > FRAME) m_busy = 1'b0;
    if (!m_busy)               exp_tx = 1'b1;
    else if (m_off <= DIV)     exp_tx = 1'b0;
    else if (m_off <= 9 * DIV) exp_tx = m_byte[(m_off - 1) / DIV - 1];
    else                       exp_tx = 1'b1;
    exp_rdy = '0;
    m_found = 1'b0;
    m_win   = 0;
    if (rstn && !m_busy) begin
      m_elig = req_valid;
`ifdef UART_ARB_LOCK_EN
      if (m_granted && req_lock[m_ptr]) m_elig = req_valid & (4'b0001 << m_ptr);
`endif
      for (int k = 1; k <= NREQ; k++) begin
        m_idx = (m_ptr + k) % NREQ;
        if (!m_found && m_elig[m_idx]) begin
          m_found = 1'b1;
          m_win   = m_idx;
          exp_rdy[m_idx] = 1'b1;
        end
      end
    end
    check("m_req_ready", req_ready, exp_rdy);
    check("m_uart_tx", uart_tx, exp_tx);
    check("m_busy", busy, m_busy);
    check("m_grant_id", grant_id, m_gid);
    if (!rstn) begin
      m_ptr = NREQ - 1;
      m_gid = 0;
      m_busy = 1'b0;
      m_granted = 1'b0;
    end else if (m_found && req_valid[m_win]) begin
      m_log.push_back(m_win);
      m_t = cyc;
      m_busy = 1'b1;
      m_granted = 1'b1;
      m_ptr = m_win;
      m_gid = m_win;
      m_byte = req_data[8*m_win +: 8];
    end
  end

  // Waits (bounded) for a handshake on the DUT; reports the requester and cycles waited
  task automatic wait_accept(output int id, output int waited);
    id = -1;
    waited = 0;
    for (int k = 0; k < 200 && id < 0; k++) begin
      @(negedge clk);
      waited++;
      for (int i = 0; i < NREQ; i++) begin
        if (req_valid[i] && req_ready[i]) id = i;
      end
    end
    check("accept_seen", (id >= 0), 1);
  endtask

  task automatic do_reset();
    @(posedge clk); #1;
    rstn = 1'b0;
    req_valid = '0;
    repeat (2) @(posedge clk);
    #1 rstn = 1'b1;
  endtask

  int id;
  int waited;
  int exp_order3[5] = '{0, 1, 2, 3, 0};
  int exp_order4[4] = '{1, 3, 1, 3};
  int exp_log[$];

  initial begin
    // Reset held with every requester valid
    req_valid = 4'hF;
    repeat (3) begin
      @(negedge clk);
      check("rst_uart_tx", uart_tx, 1);
      check("rst_req_ready", req_ready, 0);
      check("rst_busy", busy, 0);
      check("rst_grant_id", grant_id, 0);
    end

    // Single 0x55 frame from requester 0
    @(posedge clk); #1;
    rstn = 1'b1;
    req_valid = 4'b0001;
    req_data = {8'h00, 8'h00, 8'h00, 8'h55};
    wait_accept(id, waited);
    check("t2_id", id, 0);
    check("t2_latency", waited, 1);
    @(posedge clk); #1 req_valid = '0;
    for (int j = 1; j <= FRAME; j++) begin
      @(negedge clk);
      check("t2_tx", uart_tx, ((j - 1) / DIV) % 2);
      check("t2_busy", busy, 1);
    end
    @(negedge clk);
    check("t2_busy_end", busy, 0);
    check("t2_tx_end", uart_tx, 1);

    // All requesters permanently valid
    do_reset();
    req_valid = 4'hF;
    req_data = {8'hD3, 8'hC2, 8'hB1, 8'hA0};
    for (int n = 0; n < 5; n++) begin
      wait_accept(id, waited);
      check("t3_order", id, exp_order3[n]);
      if (n > 0) check("t3_spacing", waited, FRAME + 1);
    end

    // Only requesters 1 and 3 valid
    @(posedge clk); #1 req_valid = 4'b1010;
    for (int n = 0; n < 4; n++) begin
      wait_accept(id, waited);
      check("t4_order", id, exp_order4[n]);
      @(negedge clk);
      check("t4_grant_id", grant_id, exp_order4[n]);
    end
    @(posedge clk); #1 req_valid = '0;

`ifdef UART_ARB_LOCK_EN
    // Requester 2 holds the line across three bytes while requester 0 waits
    do_reset();
    req_lock = 4'b0100;
    req_valid = 4'b0100;
    req_data = {8'h00, 8'h41, 8'h00, 8'h30};
    wait_accept(id, waited);
    check("t5_first", id, 2);
    @(posedge clk); #1;
    req_valid = 4'b0101;
    req_data[23:16] = 8'h42;
    wait_accept(id, waited);
    check("t5_second", id, 2);
    @(posedge clk); #1 req_valid = 4'b0001;
    repeat (50) @(negedge clk);
    check("t5_locked_out", req_ready, 0);
    @(posedge clk); #1;
    req_valid = 4'b0101;
    req_data[23:16] = 8'h43;
    wait_accept(id, waited);
    check("t5_third", id, 2);
    @(posedge clk); #1;
    req_lock = '0;
    req_valid = 4'b0001;
    wait_accept(id, waited);
    check("t5_after_unlock", id, 0);
    @(posedge clk); #1 req_valid = '0;
`endif

    // Reset during data bit 3 aborts the frame
    do_reset();
    req_valid = 4'hF;
    req_data = {8'h13, 8'h12, 8'h11, 8'hF7};
    wait_accept(id, waited);
    check("t6_first", id, 0);
    repeat (17) @(negedge clk);
    @(posedge clk); #1 rstn = 1'b0;
    @(negedge clk);
    check("t6_bit3_tx", uart_tx, 0);
    check("t6_bit3_busy", busy, 1);
    @(negedge clk);
    check("t6_abort_tx", uart_tx, 1);
    check("t6_abort_busy", busy, 0);
    check("t6_abort_ready", req_ready, 0);
    @(posedge clk); #1 rstn = 1'b1;
    wait_accept(id, waited);
    check("t6_restart_id", id, 0);
    check("t6_restart_latency", waited, 1);
    @(posedge clk); #1 req_valid = '0;
    repeat (FRAME + 5) @(negedge clk);

    // The model's own accept history against the hand-derived sequence
    exp_log = '{0, 0, 1, 2, 3, 0, 1, 3, 1, 3};
`ifdef UART_ARB_LOCK_EN
    exp_log.push_back(2);
    exp_log.push_back(2);
    exp_log.push_back(2);
    exp_log.push_back(0);
`endif
    exp_log.push_back(0);
    exp_log.push_back(0);
    check("model_log_len", m_log.size(), exp_log.size());
    for (int n = 0; n < exp_log.size() && n < m_log.size(); n++) begin
      check("model_log", m_log[n], exp_log[n]);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1);
  end

endmodule
